// File: rtl/id_stage_regfile.sv
// id_stage_regfile: decode stage with an integrated register file.
// One-entry output slot with valid/ready handshake, flush, and write-back port.
// Optional feature: define ID_STAGE_BYPASS_EN to forward write-back data into
// operands on capture and to refresh operands of a held instruction.
module id_stage_regfile #(
   parameter int DATA_W  = 16,
   parameter int NREGS   = 16,
   parameter int INSTR_W = 20
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [INSTR_W-1:0]         instruction_i,
   input  logic                       flush_i,
   input  logic                       wb_en_i,
   input  logic [$clog2(NREGS)-1:0]   wb_addr_i,
   input  logic [DATA_W-1:0]          wb_data_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [3:0]                 out_opcode_o,
   output logic [$clog2(NREGS)-1:0]   out_rd_o,
   output logic                       out_rd_we_o,
   output logic [DATA_W-1:0]          out_rs1_data_o,
   output logic [DATA_W-1:0]          out_rs2_data_o,
   output logic [DATA_W-1:0]          out_imm_o
);

   localparam int         ADDR_W   = $clog2(NREGS);
   localparam int         IMM_W    = INSTR_W - 4 - 3 * ADDR_W;
   localparam logic [3:0] OP_STORE = 4'b1100;

   // Register file
   logic [DATA_W-1:0] rf_q [NREGS];

   // Output slot
   logic              out_valid_q,    out_valid_d;
   logic [3:0]        out_opcode_q,   out_opcode_d;
   logic [ADDR_W-1:0] out_rd_q,       out_rd_d;
   logic              out_rd_we_q,    out_rd_we_d;
   logic [DATA_W-1:0] out_rs1_data_q, out_rs1_data_d;
   logic [DATA_W-1:0] out_rs2_data_q, out_rs2_data_d;
   logic [DATA_W-1:0] out_imm_q,      out_imm_d;
`ifdef ID_STAGE_BYPASS_EN
   logic [ADDR_W-1:0] rs1_addr_q,     rs1_addr_d;
   logic [ADDR_W-1:0] rs2_addr_q,     rs2_addr_d;
`endif

   // Decoded fields of the offered instruction
   logic [3:0]        dec_opcode;
   logic [ADDR_W-1:0] dec_a, dec_b, dec_c;
   logic              dec_store;
   logic [ADDR_W-1:0] dec_rs1_addr, dec_rs2_addr;
   logic [DATA_W-1:0] dec_rs1_data, dec_rs2_data;
   logic [DATA_W-1:0] dec_imm;

   logic capture;
   logic load;

   assign in_ready_o = !out_valid_q || out_ready_i;
   assign capture    = in_valid_i && in_ready_o;
   // A flush in the capture cycle drops the accepted instruction entirely.
   assign load       = capture && !flush_i;

   assign dec_opcode   = instruction_i[INSTR_W-1 -: 4];
   assign dec_a        = instruction_i[INSTR_W-5 -: ADDR_W];
   assign dec_b        = instruction_i[INSTR_W-5-ADDR_W -: ADDR_W];
   assign dec_c        = instruction_i[INSTR_W-5-2*ADDR_W -: ADDR_W];
   assign dec_store    = (dec_opcode == OP_STORE);
   // Stores read the address register A and the data register B.
   assign dec_rs1_addr = dec_store ? dec_a : dec_b;
   assign dec_rs2_addr = dec_store ? dec_b : dec_c;

   // Immediate occupies the low IMM_W bits and is zero-extended.
   generate
      if (IMM_W == 0) begin : g_no_imm
         assign dec_imm = '0;
      end else begin : g_imm
         assign dec_imm = DATA_W'(instruction_i[IMM_W-1:0]);
      end
   endgenerate

   // Operand read, optionally forwarding a same-edge write-back
   always_comb begin
      dec_rs1_data = rf_q[dec_rs1_addr];
      dec_rs2_data = rf_q[dec_rs2_addr];
`ifdef ID_STAGE_BYPASS_EN
      if (wb_en_i && (wb_addr_i == dec_rs1_addr)) dec_rs1_data = wb_data_i;
      if (wb_en_i && (wb_addr_i == dec_rs2_addr)) dec_rs2_data = wb_data_i;
`endif
   end

   // Register file write; writes ignore stall and flush
   always_ff @(posedge clock_i or posedge reset_i) begin
      // NOTE: this array is reset on purpose: every architectural register must read 0 after reset.
      if (reset_i) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else if (wb_en_i) begin
         rf_q[wb_addr_i] <= wb_data_i;
      end
   end

   // Output slot next state: capture, drain, flush and optional operand refresh
   always_comb begin
      // NOTE: every output gets its hold value first so no path leaves it unassigned (no latch).
      out_valid_d    = out_valid_q;
      out_opcode_d   = out_opcode_q;
      out_rd_d       = out_rd_q;
      out_rd_we_d    = out_rd_we_q;
      out_rs1_data_d = out_rs1_data_q;
      out_rs2_data_d = out_rs2_data_q;
      out_imm_d      = out_imm_q;
`ifdef ID_STAGE_BYPASS_EN
      rs1_addr_d     = rs1_addr_q;
      rs2_addr_d     = rs2_addr_q;
`endif

      if (flush_i)          out_valid_d = 1'b0;
      else if (capture)     out_valid_d = 1'b1;
      else if (out_ready_i) out_valid_d = 1'b0;

      if (load) begin
         out_opcode_d   = dec_opcode;
         out_rd_d       = dec_a;
         out_rd_we_d    = !dec_store;
         out_rs1_data_d = dec_rs1_data;
         out_rs2_data_d = dec_rs2_data;
         out_imm_d      = dec_imm;
`ifdef ID_STAGE_BYPASS_EN
         rs1_addr_d     = dec_rs1_addr;
         rs2_addr_d     = dec_rs2_addr;
      end else if (out_valid_q && !out_ready_i && !flush_i) begin
         // A held instruction picks up write-backs to its source registers.
         if (wb_en_i && (wb_addr_i == rs1_addr_q)) out_rs1_data_d = wb_data_i;
         if (wb_en_i && (wb_addr_i == rs2_addr_q)) out_rs2_data_d = wb_data_i;
`endif
      end
   end

   // Output slot registers
   always_ff @(posedge clock_i or posedge reset_i) begin
      // NOTE: state registers use non-blocking assignments so all update together at the edge.
      if (reset_i) begin
         out_valid_q    <= 1'b0;
         out_opcode_q   <= '0;
         out_rd_q       <= '0;
         out_rd_we_q    <= 1'b0;
         out_rs1_data_q <= '0;
         out_rs2_data_q <= '0;
         out_imm_q      <= '0;
`ifdef ID_STAGE_BYPASS_EN
         rs1_addr_q     <= '0;
         rs2_addr_q     <= '0;
`endif
      end else begin
         out_valid_q    <= out_valid_d;
         out_opcode_q   <= out_opcode_d;
         out_rd_q       <= out_rd_d;
         out_rd_we_q    <= out_rd_we_d;
         out_rs1_data_q <= out_rs1_data_d;
         out_rs2_data_q <= out_rs2_data_d;
         out_imm_q      <= out_imm_d;
`ifdef ID_STAGE_BYPASS_EN
         rs1_addr_q     <= rs1_addr_d;
         rs2_addr_q     <= rs2_addr_d;
`endif
      end
   end

   assign out_valid_o    = out_valid_q;
   assign out_opcode_o   = out_opcode_q;
   assign out_rd_o       = out_rd_q;
   assign out_rd_we_o    = out_rd_we_q;
   assign out_rs1_data_o = out_rs1_data_q;
   assign out_rs2_data_o = out_rs2_data_q;
   assign out_imm_o      = out_imm_q;

endmodule

// File: tb/tb_id_stage_regfile.sv
// Scoreboard bench for id_stage_regfile: stimulus pushes expected decoded
// instructions, a monitor pops and compares on each output handshake.
module tb_id_stage_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, flush, wb_en;
   logic [19:0] instr;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        out_valid, out_ready, out_rd_we;
   logic [3:0]  out_opcode, out_rd;
   logic [15:0] out_rs1, out_rs2, out_imm;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  rd;
      logic        we;
      logic [15:0] rs1;
      logic [15:0] rs2;
      logic [15:0] imm;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   id_stage_regfile dut (
      .clock_i        (clk),
      .reset_i        (rst),
      .in_valid_i     (in_valid),
      .in_ready_o     (in_ready),
      .instruction_i  (instr),
      .flush_i        (flush),
      .wb_en_i        (wb_en),
      .wb_addr_i      (wb_addr),
      .wb_data_i      (wb_data),
      .out_valid_o    (out_valid),
      .out_ready_i    (out_ready),
      .out_opcode_o   (out_opcode),
      .out_rd_o       (out_rd),
      .out_rd_we_o    (out_rd_we),
      .out_rs1_data_o (out_rs1),
      .out_rs2_data_o (out_rs2),
      .out_imm_o      (out_imm)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] op, input logic [3:0] rd, input logic we,
                               input logic [15:0] rs1, input logic [15:0] rs2,
                               input logic [15:0] imm);
      exp_t e;
      e.op = op; e.rd = rd; e.we = we; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
      return e;
   endfunction

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [3:0] a, input logic [15:0] d);
      wb_en = 1'b1; wb_addr = a; wb_data = d;
      cycle();
      wb_en = 1'b0;
   endtask

   // Monitor: compare the held instruction whenever it is consumed
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_output", 32'(out_opcode), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("mon_opcode", 32'(out_opcode), 32'(e.op));
               check("mon_rd",     32'(out_rd),     32'(e.rd));
               check("mon_rd_we",  32'(out_rd_we),  32'(e.we));
               check("mon_rs1",    32'(out_rs1),    32'(e.rs1));
               check("mon_rs2",    32'(out_rs2),    32'(e.rs2));
               check("mon_imm",    32'(out_imm),    32'(e.imm));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_opcode",    32'(out_opcode), 32'd0);
      check("rst_rs1",       32'(out_rs1),   32'd0);
      check("rst_imm",       32'(out_imm),   32'd0);
      rst = 1'b0;
      cycle();

      // Basic ALU op: r3=BEEF, op1 A=5 B=3 C=7
      wb(4'd3, 16'hBEEF);
      in_valid = 1'b1; instr = 20'h1_5_3_7_0;
      sb_q.push_back(mk(4'h1, 4'd5, 1'b1, 16'hBEEF, 16'h0000, 16'h0000));
      cycle();
      in_valid = 1'b0;
      check("lat_out_valid", 32'(out_valid), 32'd1);
      cycle();
      check("drain_out_valid", 32'(out_valid), 32'd0);

      // Store: rs1=A, rs2=B, no destination write
      wb(4'd3, 16'h0011);
      wb(4'd2, 16'h0022);
      in_valid = 1'b1; instr = 20'hC_3_2_0_0;
      sb_q.push_back(mk(4'hC, 4'd3, 1'b0, 16'h0011, 16'h0022, 16'h0000));
      cycle();
      in_valid = 1'b0;
      cycle();

      // Stall: out_ready low for three cycles with a second instruction offered
      wb(4'd7, 16'h0077);
      wb(4'd8, 16'h0088);
      out_ready = 1'b0;
      in_valid = 1'b1; instr = 20'h2_1_7_8_A;
      sb_q.push_back(mk(4'h2, 4'd1, 1'b1, 16'h0077, 16'h0088, 16'h000A));
      cycle();
      instr = 20'h3_2_8_7_F;
      for (int i = 0; i < 3; i++) begin
         check("stall_in_ready", 32'(in_ready),   32'd0);
         check("stall_opcode",   32'(out_opcode), 32'h2);
         check("stall_rs1",      32'(out_rs1),    32'h0077);
         check("stall_imm",      32'(out_imm),    32'h000A);
         cycle();
      end
      out_ready = 1'b1;
      sb_q.push_back(mk(4'h3, 4'd2, 1'b1, 16'h0088, 16'h0077, 16'h000F));
      cycle();
      in_valid = 1'b0;
      check("stall_second_held", 32'(out_opcode), 32'h3);
      cycle();

      // Same-edge write-back versus capture, then write while held
      wb(4'd4, 16'h0044);
      out_ready = 1'b0;
      wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'h1234;
      in_valid = 1'b1; instr = 20'h4_9_4_0_0;
`ifdef ID_STAGE_BYPASS_EN
      sb_q.push_back(mk(4'h4, 4'd9, 1'b1, 16'h1234, 16'h0000, 16'h0000));
`else
      sb_q.push_back(mk(4'h4, 4'd9, 1'b1, 16'h0044, 16'h0000, 16'h0000));
`endif
      cycle();
      in_valid = 1'b0; wb_en = 1'b0;
      wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'h5678;
`ifdef ID_STAGE_BYPASS_EN
      sb_q[0].rs1 = 16'h5678;
`endif
      cycle();
      wb_en = 1'b0;
      out_ready = 1'b1;
      cycle();
      // Both writes landed in r4 regardless of the stall
      in_valid = 1'b1; instr = 20'h5_1_4_4_3;
      sb_q.push_back(mk(4'h5, 4'd1, 1'b1, 16'h5678, 16'h5678, 16'h0003));
      cycle();
      in_valid = 1'b0;
      cycle();

      // Flush with a held instruction and a new offer
      out_ready = 1'b0;
      in_valid = 1'b1; instr = 20'h6_2_3_2_1;
      cycle();
      instr = 20'h7_0_0_0_0; flush = 1'b1;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", 32'(out_valid),  32'd0);
      check("flush_keep_op",   32'(out_opcode), 32'h6);
      check("flush_keep_rs1",  32'(out_rs1),    32'h0011);
      check("flush_in_ready",  32'(in_ready),   32'd1);

      // Reset while stalled
      in_valid = 1'b1; instr = 20'h8_1_2_3_0;
      cycle();
      instr = 20'h9_0_0_0_0;
      cycle();
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_valid",  32'(out_valid),  32'd0);
      check("async_rst_opcode", 32'(out_opcode), 32'd0);
      check("async_rst_rs2",    32'(out_rs2),    32'd0);
      in_valid = 1'b0; out_ready = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      // Registers read back as zero after reset
      in_valid = 1'b1; instr = 20'h1_5_3_2_0;
      sb_q.push_back(mk(4'h1, 4'd5, 1'b1, 16'h0000, 16'h0000, 16'h0000));
      cycle();
      in_valid = 1'b0;

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) cycle();
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_stage_regfile.md
ID_STAGE_REGFILE -- requirements
Module: id_stage_regfile

Interface
REQ-001 Parameter DATA_W, 16, register and operand width in bits.
REQ-002 Parameter NREGS, 16, number of architectural registers (power of two, >=2); ADDR_W = log2(NREGS).
REQ-003 Parameter INSTR_W, 20, instruction width; legal only if INSTR_W >= 4+3*ADDR_W; IMM_W = INSTR_W-4-3*ADDR_W.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  instruction offered by fetch.
REQ-007 in_ready  out  1  stage can accept an instruction this cycle.
REQ-008 instruction  in  INSTR_W  fields: opcode [INSTR_W-1 -: 4], A, B, C (ADDR_W each, descending), imm (low IMM_W bits).
REQ-009 flush  in  1  discard held instruction.
REQ-010 wb_en / wb_addr / wb_data  in  1 / ADDR_W / DATA_W  write-back port.
REQ-011 out_valid  out  1  decoded instruction held.
REQ-012 out_ready  in  1  execute consumes held instruction.
REQ-013 out_opcode / out_rd / out_rd_we  out  4 / ADDR_W / 1  opcode, destination, destination write flag.
REQ-014 out_rs1_data / out_rs2_data / out_imm  out  DATA_W each  operands; imm zero-extended.

Function
REQ-015 Register file: NREGS x DATA_W; write when wb_en=1 at rising edge; writes proceed regardless of stall or flush.
REQ-016 Store (opcode 4'b1100): rs1=A, rs2=B, out_rd=A, out_rd_we=0.
REQ-017 All other opcodes: rs1=B, rs2=C, out_rd=A, out_rd_we=1.
REQ-018 in_ready = !out_valid || out_ready (combinational); no dependency on in_valid.
REQ-019 Capture when in_valid && in_ready: next edge loads all out_* fields and sets out_valid=1; latency one cycle.
REQ-020 out_valid && out_ready && !(in_valid && in_ready) clears out_valid at next edge.
REQ-021 out_valid && !out_ready: all out_* held stable except operand refresh per REQ-027.
REQ-022 flush=1: out_valid=0 at next edge, overrides capture; accepted instruction that cycle is dropped; out_* data fields keep their value.
REQ-023 Operand read uses register file contents before the same-edge write unless REQ-026 applies.
REQ-024 IMM_W=0: out_imm constant zero.

Reset
REQ-025 reset=1 asynchronously clears out_valid, out_opcode, out_rd, out_rd_we, out_rs1_data, out_rs2_data, out_imm and all NREGS registers to 0; in_ready=1 while out_valid=0; reset mid-transfer drops held instruction, no writeback occurs.

Configuration
REQ-026 Macro ID_STAGE_BYPASS_EN defined: on capture, if wb_en && wb_addr equals rs1 (rs2) address, operand takes wb_data instead of register contents.
REQ-027 ID_STAGE_BYPASS_EN defined: while held (out_valid && !out_ready && !flush), wb_en with wb_addr equal to the held rs1 (rs2) address replaces out_rs1_data (out_rs2_data) with wb_data at that edge; held source addresses stored internally.
REQ-028 ID_STAGE_BYPASS_EN undefined: no bypass, no refresh; operands are register contents sampled at capture edge; execute handles hazards.

Verification
REQ-029 Reset, then wb_en=1 addr 3 data 16'hBEEF; next cycle instruction 20'h1_5_3_7_0 (op 1, A=5, B=3, C=7) -> out_valid=1 one cycle later, out_rs1_data=16'hBEEF, out_rs2_data=0, out_rd=5, out_rd_we=1.
REQ-030 Store 20'hC_3_2_0_0 with r3=16'h0011, r2=16'h0022 -> out_rs1_data=16'h0011, out_rs2_data=16'h0022, out_rd_we=0.
REQ-031 out_ready=0 three cycles with in_valid=1 -> in_ready=0, outputs stable, second instruction captured only after out_ready=1.
REQ-032 Same edge wb_en addr 4 data 16'h1234 and capture reading B=4 -> 16'h1234 with ID_STAGE_BYPASS_EN, old r4 without; held-slot write to r4 refreshes only with macro.
REQ-033 flush=1 with in_valid=1 and out_valid=1 -> out_valid=0 next cycle; reset asserted mid-stall -> out_valid=0 and all registers 0 immediately.
